// File: rtl/hazard_fwd_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_fwd_ctrl
//
// Hazard and forwarding controller for a 5-stage pipeline. Tracks the
// destination registers of the instructions in EX, MEM and WB, produces the
// EX-stage operand forward selects, and generates the stall, flush, bubble
// and hold controls for load-use hazards, multi-cycle MDU operations and
// taken branches.
//
// Ports:
//   clk, reset              clock (rising edge), synchronous active-high reset
//   id_valid                ID holds a real instruction
//   id_rs, id_rt            ID source register indices
//   id_uses_rs, id_uses_rt  the corresponding source is actually read
//   id_rd, id_we            ID destination index and write enable
//   id_is_load, id_is_mdu   ID instruction class
//   ex_branch_taken         branch in EX resolved taken this cycle
//   stall_if                hold PC and IF/ID                (combinational)
//   flush_if_id             clear IF/ID                      (combinational)
//   bubble_ex               load NOP into ID/EX              (combinational)
//   bubble_mem              load NOP into EX/MEM             (combinational)
//   hold_ex                 hold ID/EX and EX-stage state    (combinational)
//   fwd_a_sel, fwd_b_sel    EX operand mux selects           (registered)
//                           00 regfile, 01 EX/MEM, 10 MEM/WB
//   mdu_busy                MDU countdown active             (registered)
// -----------------------------------------------------------------------------
module hazard_fwd_ctrl #(
    parameter int REGW       = 5,
    parameter int MDU_CYCLES = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            id_valid,
    input  logic [REGW-1:0] id_rs,
    input  logic [REGW-1:0] id_rt,
    input  logic            id_uses_rs,
    input  logic            id_uses_rt,
    input  logic [REGW-1:0] id_rd,
    input  logic            id_we,
    input  logic            id_is_load,
    input  logic            id_is_mdu,
    input  logic            ex_branch_taken,
    output logic            stall_if,
    output logic            flush_if_id,
    output logic            bubble_ex,
    output logic            bubble_mem,
    output logic            hold_ex,
    output logic [1:0]      fwd_a_sel,
    output logic [1:0]      fwd_b_sel,
    output logic            mdu_busy
);

    localparam int CW = $clog2(MDU_CYCLES) + 1;
    localparam logic [CW-1:0] MDU_LOAD = CW'(MDU_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef struct packed {
        logic            valid;
        logic            we;
        logic [REGW-1:0] rd;
        logic            is_load;
        logic            is_mdu;
    } entry_t;

    typedef enum logic [1:0] {
        MODE_RUN,
        MODE_LOADUSE,
        MODE_FLUSH,
        MODE_BUSY
    } mode_t;

    entry_t          ex_q, mem_q, wb_q;
    entry_t          id_entry;
    logic [CW-1:0]   mdu_cnt;
    mode_t           mode;
    logic            load_use;
    logic [1:0]      sel_a_next, sel_b_next;

    // Register 0 is hard-wired, so a write to it never produces a hazard.
    function automatic logic match(entry_t e, logic [REGW-1:0] r);
        return e.valid & e.we & (e.rd == r) & (r != '0);
    endfunction

    // The youngest producer (EX) wins over the older one (MEM).
    function automatic logic [1:0] fwd_sel(entry_t ex_e, entry_t mem_e,
                                           logic used, logic [REGW-1:0] r);
        if (used && match(ex_e, r))
            return 2'b01;
        else if (used && match(mem_e, r))
            return 2'b10;
        else
            return 2'b00;
    endfunction

    assign id_entry = '{valid: id_valid, we: id_we, rd: id_rd,
                        is_load: id_is_load, is_mdu: id_is_mdu};

    // -------------------------------------------------------------------------
    // Next-mode decision, highest priority first.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        mode       = MODE_RUN;
        load_use   = id_valid & ex_q.is_load &
                     ((id_uses_rs & match(ex_q, id_rs)) |
                      (id_uses_rt & match(ex_q, id_rt)));
        sel_a_next = fwd_sel(ex_q, mem_q, id_uses_rs, id_rs);
        sel_b_next = fwd_sel(ex_q, mem_q, id_uses_rt, id_rt);
        if (mdu_cnt != '0)
            mode = MODE_BUSY;
        else if (ex_branch_taken)
            mode = MODE_FLUSH;
        else if (load_use)
            mode = MODE_LOADUSE;
    end

    // -------------------------------------------------------------------------
    // Tracker, forward selects and MDU countdown.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (reset) begin
            ex_q      <= '0;
            mem_q     <= '0;
            wb_q      <= '0;
            mdu_cnt   <= '0;
            fwd_a_sel <= 2'b00;
            fwd_b_sel <= 2'b00;
        end else begin
            case (mode)
                MODE_BUSY: begin
                    // MDU instruction stays in EX; its selects stay too.
                    mem_q   <= '0;
                    wb_q    <= mem_q;
                    mdu_cnt <= mdu_cnt - CNT_ONE;
                end
                MODE_FLUSH, MODE_LOADUSE: begin
                    ex_q      <= '0;
                    mem_q     <= ex_q;
                    wb_q      <= mem_q;
                    fwd_a_sel <= 2'b00;
                    fwd_b_sel <= 2'b00;
                end
                default: begin
                    ex_q      <= id_valid ? id_entry : '0;
                    mem_q     <= ex_q;
                    wb_q      <= mem_q;
                    fwd_a_sel <= sel_a_next;
                    fwd_b_sel <= sel_b_next;
                    if (id_valid && id_is_mdu && (MDU_CYCLES > 1))
                        mdu_cnt <= MDU_LOAD;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Mode-dependent pipeline controls. Held at 0 during reset so a stale
    // countdown or tracker entry cannot stall the front end.
    // -------------------------------------------------------------------------
    always_comb begin
        stall_if    = 1'b0;
        flush_if_id = 1'b0;
        bubble_ex   = 1'b0;
        bubble_mem  = 1'b0;
        hold_ex     = 1'b0;
        if (!reset) begin
            case (mode)
                MODE_BUSY: begin
                    stall_if   = 1'b1;
                    hold_ex    = 1'b1;
                    bubble_mem = 1'b1;
                end
                MODE_FLUSH: begin
                    flush_if_id = 1'b1;
                    bubble_ex   = 1'b1;
                end
                MODE_LOADUSE: begin
                    stall_if  = 1'b1;
                    bubble_ex = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign mdu_busy = (mdu_cnt != '0);

    // The WB entry and the class bits of older entries do not steer any
    // control; they are kept so the tracker mirrors the whole back end.
    logic unused_tracker;
    assign unused_tracker = ^{wb_q, mem_q.is_load, mem_q.is_mdu, ex_q.is_mdu};

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
module tb_hazard_fwd_ctrl;

    localparam int MDU_CYCLES = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid;
    logic [4:0] id_rs, id_rt, id_rd;
    logic       id_uses_rs, id_uses_rt, id_we, id_is_load, id_is_mdu;
    logic       ex_branch_taken;
    logic       stall_if, flush_if_id, bubble_ex, bubble_mem, hold_ex, mdu_busy;
    logic [1:0] fwd_a_sel, fwd_b_sel;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_fwd_ctrl #(.REGW(5), .MDU_CYCLES(MDU_CYCLES)) dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_rd(id_rd), .id_we(id_we), .id_is_load(id_is_load),
        .id_is_mdu(id_is_mdu), .ex_branch_taken(ex_branch_taken),
        .stall_if(stall_if), .flush_if_id(flush_if_id),
        .bubble_ex(bubble_ex), .bubble_mem(bubble_mem), .hold_ex(hold_ex),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .mdu_busy(mdu_busy)
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Back end as an age-ordered list: slot 0 = EX, 1 = MEM, 2 = WB.
    typedef struct {
        bit       v;
        bit       we;
        bit [4:0] rd;
        bit       ld;
    } instr_t;

    instr_t   pipe [3];
    int       ex_cycles_left;   // extra cycles the MDU op still spends in EX
    int       m_sa, m_sb;

    function automatic bit writes(instr_t i, bit [4:0] r);
        return i.v && i.we && i.rd == r && r != 0;
    endfunction

    function automatic int src_sel(bit used, bit [4:0] r);
        if (!used) return 0;
        if (writes(pipe[0], r)) return 1;
        if (writes(pipe[1], r)) return 2;
        return 0;
    endfunction

    function automatic instr_t nop();
        instr_t n;
        n.v = 0; n.we = 0; n.rd = 0; n.ld = 0;
        return n;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) pipe[i] = nop();
        ex_cycles_left = 0;
        m_sa = 0;
        m_sb = 0;
    endtask

    // One clock: check all outputs against the model, then advance both.
    task automatic tick();
        bit busy, br, lu;
        int e_stall, e_flush, e_bex, e_bmem, e_hold;
        #1;
        busy = ex_cycles_left > 0;
        br   = !busy && ex_branch_taken;
        lu   = !busy && !br && id_valid && pipe[0].ld &&
               ((id_uses_rs && writes(pipe[0], id_rs)) ||
                (id_uses_rt && writes(pipe[0], id_rt)));
        e_stall = 0; e_flush = 0; e_bex = 0; e_bmem = 0; e_hold = 0;
        if (!reset) begin
            e_stall = (busy || lu) ? 1 : 0;
            e_hold  = busy ? 1 : 0;
            e_bmem  = busy ? 1 : 0;
            e_flush = br ? 1 : 0;
            e_bex   = (br || lu) ? 1 : 0;
        end
        check("stall_if",    int'(stall_if),    e_stall);
        check("flush_if_id", int'(flush_if_id), e_flush);
        check("bubble_ex",   int'(bubble_ex),   e_bex);
        check("bubble_mem",  int'(bubble_mem),  e_bmem);
        check("hold_ex",     int'(hold_ex),     e_hold);
        check("fwd_a_sel",   int'(fwd_a_sel),   m_sa);
        check("fwd_b_sel",   int'(fwd_b_sel),   m_sb);
        check("mdu_busy",    int'(mdu_busy),    busy ? 1 : 0);

        if (reset) begin
            model_reset();
        end else if (busy) begin
            pipe[2] = pipe[1];
            pipe[1] = nop();
            ex_cycles_left--;
        end else if (br || lu) begin
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = nop();
            m_sa = 0;
            m_sb = 0;
        end else begin
            instr_t n;
            m_sa = src_sel(id_uses_rs, id_rs);
            m_sb = src_sel(id_uses_rt, id_rt);
            n = nop();
            if (id_valid) begin
                n.v = 1; n.we = id_we; n.rd = id_rd; n.ld = id_is_load;
            end
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = n;
            if (id_valid && id_is_mdu) ex_cycles_left = MDU_CYCLES - 1;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_id(input bit v, input bit [4:0] rs, input bit urs,
                          input bit [4:0] rt, input bit urt, input bit [4:0] rd,
                          input bit we, input bit ld, input bit mdu);
        id_valid = v; id_rs = rs; id_uses_rs = urs; id_rt = rt; id_uses_rt = urt;
        id_rd = rd; id_we = we; id_is_load = ld; id_is_mdu = mdu;
    endtask

    task automatic idle();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        ex_branch_taken = 0;
    endtask

    initial begin
        @(negedge clk);
        reset = 1;
        idle();
        model_reset();
        tick();
        tick();
        reset = 0;
        tick();
        check("reset_sel_a", int'(fwd_a_sel), 0);

        // add r3 ; sub using r3 -> EX forward
        set_id(1, 1, 1, 2, 1, 3, 1, 0, 0); tick();
        set_id(1, 3, 1, 2, 1, 7, 1, 0, 0); tick();
        check("ex_fwd_a", int'(fwd_a_sel), 1);

        // add r3 ; unrelated ; use r3 -> MEM forward
        set_id(1, 1, 1, 2, 1, 3, 1, 0, 0); tick();
        set_id(1, 1, 1, 2, 1, 9, 1, 0, 0); tick();
        set_id(1, 3, 1, 0, 0, 11, 1, 0, 0); tick();
        check("mem_fwd_a", int'(fwd_a_sel), 2);

        // write r0 ; read r0 -> no forward
        set_id(1, 1, 1, 2, 1, 0, 1, 0, 0); tick();
        set_id(1, 0, 1, 0, 1, 12, 1, 0, 0); tick();
        check("r0_fwd_a", int'(fwd_a_sel), 0);
        check("r0_fwd_b", int'(fwd_b_sel), 0);

        // lw r5 ; add r6,r5,r5 -> one-cycle stall then 10/10
        set_id(1, 1, 1, 0, 0, 5, 1, 1, 0); tick();
        set_id(1, 5, 1, 5, 1, 6, 1, 0, 0);
        #1 check("lu_stall", int'(stall_if), 1);
        check("lu_bubble", int'(bubble_ex), 1);
        tick();
        #1 check("lu_nostall", int'(stall_if), 0);
        tick();
        check("lu_fwd_a", int'(fwd_a_sel), 2);
        check("lu_fwd_b", int'(fwd_b_sel), 2);

        // MDU writing r8 ; dependent reader
        set_id(1, 1, 1, 2, 1, 8, 1, 0, 1); tick();
        set_id(1, 8, 1, 0, 0, 13, 1, 0, 0);
        for (int i = 0; i < MDU_CYCLES - 1; i++) begin
            #1 check("mdu_busy", int'(mdu_busy), 1);
            check("mdu_stall", int'(stall_if & hold_ex & bubble_mem), 1);
            tick();
        end
        check("mdu_done", int'(mdu_busy), 0);
        tick();
        check("mdu_fwd_a", int'(fwd_a_sel), 1);

        // load-use and branch in the same cycle -> branch wins
        set_id(1, 1, 1, 0, 0, 5, 1, 1, 0); tick();
        set_id(1, 5, 1, 0, 0, 6, 1, 0, 0);
        ex_branch_taken = 1;
        #1 check("br_flush", int'(flush_if_id), 1);
        check("br_bubble", int'(bubble_ex), 1);
        check("br_nostall", int'(stall_if), 0);
        tick();
        ex_branch_taken = 0;
        #1 check("br_after", int'(stall_if), 0);
        tick();

        // r4 written twice back to back; reader sees newest (EX)
        set_id(1, 1, 1, 0, 0, 4, 1, 0, 0); tick();
        set_id(1, 2, 1, 0, 0, 4, 1, 0, 0); tick();
        set_id(1, 0, 0, 4, 1, 14, 1, 0, 0); tick();
        check("newest_fwd_b", int'(fwd_b_sel), 1);

        // reset on the 2nd BUSY cycle
        set_id(1, 1, 1, 2, 1, 8, 1, 0, 1); tick();
        idle(); tick();
        reset = 1; tick();
        reset = 0;
        #1 check("rst_busy", int'(mdu_busy), 0);
        check("rst_stall", int'(stall_if | hold_ex | bubble_mem), 0);
        check("rst_sels", int'({fwd_a_sel, fwd_b_sel}), 0);
        set_id(1, 1, 1, 0, 0, 10, 1, 0, 0); tick();
        set_id(1, 10, 1, 0, 0, 15, 1, 0, 0); tick();
        check("rst_resume", int'(fwd_a_sel), 1);

        // randomized traffic on a small register set to provoke hazards
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 99) == 0);
            set_id($urandom_range(0, 7) != 0,
                   5'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
                   5'($urandom_range(0, 7)), $urandom_range(0, 1) != 0,
                   5'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
                   $urandom_range(0, 3) == 0, $urandom_range(0, 11) == 0);
            ex_branch_taken = ($urandom_range(0, 9) == 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
